// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the instruction fetch unit and its users.
//   state_t      - fetch FSM state encoding (IDLE, REQ, HOLD)
//   INSTR_W      - instruction / address width
//   PC_INC       - sequential fetch stride in bytes
//   align_word() - clears the two byte-offset bits of an address
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cpu_fetchunit.sv
// cpu_fetchunit: single-outstanding-request instruction fetch unit.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   mem_req, mem_addr   - instruction memory read request / word address
//   mem_ack, mem_rdata  - read completion strobe and instruction word
//   instr, instr_pc     - fetched instruction and its address to the datapath
//   instr_valid         - instr/instr_pc valid
//   instr_ready         - datapath accepts instr this cycle
//   redirect, redirect_pc - jump / taken-branch request and target
module cpu_fetchunit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc
);

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [31:0]        r_instr_pc;
    logic               r_instr_valid;
    logic               r_kill;
    logic [31:0]        r_kill_pc;

    state_t             w_state_next;
    logic [31:0]        w_pc_next;
    logic [INSTR_W-1:0] w_instr_next;
    logic [31:0]        w_instr_pc_next;
    logic               w_instr_valid_next;
    logic               w_kill_next;
    logic [31:0]        w_kill_pc_next;
    logic [31:0]        w_redirect_aligned;

    assign w_redirect_aligned = align_word(redirect_pc);

    // The request address is the fetch PC itself; a redirect during an
    // outstanding request goes to r_kill_pc so the address stays stable.
    assign mem_req     = (r_state == ST_REQ);
    assign mem_addr    = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_instr_next       = r_instr;
        w_instr_pc_next    = r_instr_pc;
        w_instr_valid_next = r_instr_valid;
        w_kill_next        = r_kill;
        w_kill_pc_next     = r_kill_pc;

        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_REQ;
                if (redirect) begin
                    w_pc_next = w_redirect_aligned;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (r_kill || redirect) begin
                        // Stale data: drop it and restart at the newest target.
                        w_kill_next = 1'b0;
                        w_pc_next   = redirect ? w_redirect_aligned : r_kill_pc;
                    end else begin
                        w_instr_next       = mem_rdata;
                        w_instr_pc_next    = r_pc;
                        w_instr_valid_next = 1'b1;
                        w_state_next       = ST_HOLD;
                    end
                end else if (redirect) begin
                    w_kill_next    = 1'b1;
                    w_kill_pc_next = w_redirect_aligned;
                end
            end
            ST_HOLD: begin
                // A redirect wins over a simultaneous handshake for the next PC.
                if (redirect) begin
                    w_instr_valid_next = 1'b0;
                    w_pc_next          = w_redirect_aligned;
                    w_state_next       = ST_REQ;
                end else if (r_instr_valid && instr_ready) begin
                    w_instr_valid_next = 1'b0;
                    w_pc_next          = r_pc + PC_INC;
                    w_state_next       = ST_REQ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_kill        <= 1'b0;
            r_kill_pc     <= RESET_PC;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instr       <= w_instr_next;
            r_instr_pc    <= w_instr_pc_next;
            r_instr_valid <= w_instr_valid_next;
            r_kill        <= w_kill_next;
            r_kill_pc     <= w_kill_pc_next;
        end
    end

endmodule

// File: tb/tb_cpu_fetchunit.sv
// tb_cpu_fetchunit: directed self-checking bench for cpu_fetchunit.
module tb_cpu_fetchunit;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_cmp;
    int n_bad;

    cpu_fetchunit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        step(); step();
        n_cmp++;
        if ({mem_req, mem_addr, instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h pc=%h, want 0/0/0/0/0",
                     mem_req, mem_addr, instr_valid, instr, instr_pc);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
            n_bad++;
            $display("FAIL first_req: req=%b addr=%h, want 1/00000000", mem_req, mem_addr);
        end
        $display("reset: released, first request at %h", mem_addr);
    endtask

    task automatic test_sequential();
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({mem_req, mem_addr} !== {1'b1, 32'(4 * k)}) begin
                n_bad++;
                $display("FAIL seq_addr%0d: req=%b addr=%h, want 1/%h", k, mem_req, mem_addr, 32'(4 * k));
            end
            step();
            mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(k);
            step();
            mem_ack = 1'b0;
            n_cmp++;
            if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hA000_0000 + 32'(k), 32'(4 * k)}) begin
                n_bad++;
                $display("FAIL seq_instr%0d: valid=%b instr=%h pc=%h, want 1/%h/%h",
                         k, instr_valid, instr, instr_pc, 32'hA000_0000 + 32'(k), 32'(4 * k));
            end
            $display("seq: fetched %h at %h", instr, instr_pc);
            step();
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 32'hC}) begin
            n_bad++;
            $display("FAIL bp_req: req=%b addr=%h, want 1/0000000c", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hB0B0_0001;
        step();
        mem_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({instr_valid, instr, instr_pc, mem_req} !== {1'b1, 32'hB0B0_0001, 32'hC, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold%0d: valid=%b instr=%h pc=%h req=%b, want 1/b0b00001/0000000c/0",
                         c, instr_valid, instr, instr_pc, mem_req);
            end
            // Stray ack while holding must not disturb the held instruction.
            mem_ack = (c == 2); mem_rdata = 32'hDEAD_BEEF;
            step();
        end
        mem_ack = 1'b0;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        n_cmp++;
        if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h10}) begin
            n_bad++;
            $display("FAIL bp_next: valid=%b req=%b addr=%h, want 0/1/00000010", instr_valid, mem_req, mem_addr);
        end
        $display("backpressure: held 5 cycles, next request at %h", mem_addr);
    endtask

    task automatic test_redirect_hold();
        mem_ack = 1'b1; mem_rdata = 32'hC0C0_0002;
        step();
        mem_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        n_cmp++;
        if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            n_bad++;
            $display("FAIL redir_hold: valid=%b req=%b addr=%h, want 0/1/00000100", instr_valid, mem_req, mem_addr);
        end
        $display("redirect_hold: next request at %h", mem_addr);
    endtask

    task automatic test_redirect_req();
        // Get to a fetch of 0x8 via a HOLD redirect.
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        mem_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h8;
        step();
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h8}) begin
            n_bad++;
            $display("FAIL kill_stable1: req=%b addr=%h, want 1/00000008", mem_req, mem_addr);
        end
        step();
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h8}) begin
            n_bad++;
            $display("FAIL kill_stable2: req=%b addr=%h, want 1/00000008", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        step();
        mem_ack = 1'b0;
        n_cmp++;
        if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h40}) begin
            n_bad++;
            $display("FAIL kill_discard: valid=%b req=%b addr=%h, want 0/1/00000040", instr_valid, mem_req, mem_addr);
        end
        $display("redirect_req: killed fetch of 8, restarted at %h", mem_addr);
    endtask

    task automatic test_kill_update();
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        step();
        mem_ack = 1'b0;
        n_cmp++;
        if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            n_bad++;
            $display("FAIL kill_newest: valid=%b req=%b addr=%h, want 0/1/00000300", instr_valid, mem_req, mem_addr);
        end
        // Ack in the same cycle as a redirect is discarded too.
        mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
        redirect = 1'b1; redirect_pc = 32'h501;
        step();
        mem_ack = 1'b0; redirect = 1'b0;
        n_cmp++;
        if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h500}) begin
            n_bad++;
            $display("FAIL ack_with_redir: valid=%b req=%b addr=%h, want 0/1/00000500", instr_valid, mem_req, mem_addr);
        end
        $display("kill_update: restarted at %h", mem_addr);
    endtask

    task automatic test_wrap();
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        n_cmp++;
        if (mem_addr !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_target: addr=%h, want fffffffc", mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hE0E0_E0E0;
        step();
        mem_ack = 1'b0;
        n_cmp++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hE0E0_E0E0, 32'hFFFF_FFFC}) begin
            n_bad++;
            $display("FAIL wrap_instr: valid=%b instr=%h pc=%h, want 1/e0e0e0e0/fffffffc", instr_valid, instr, instr_pc);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
            n_bad++;
            $display("FAIL wrap_next: req=%b addr=%h, want 1/00000000", mem_req, mem_addr);
        end
        $display("wrap: after fffffffc next request at %h", mem_addr);
    endtask

    task automatic test_back_to_back();
        // Redirect together with instr_ready in HOLD: redirect wins.
        mem_ack = 1'b1; mem_rdata = 32'h6666_6666;
        step();
        mem_ack = 1'b0;
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        step();
        instr_ready = 1'b0; redirect = 1'b0;
        n_cmp++;
        if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h80}) begin
            n_bad++;
            $display("FAIL redir_and_ready: valid=%b req=%b addr=%h, want 0/1/00000080", instr_valid, mem_req, mem_addr);
        end
        $display("back_to_back: redirect with ready -> %h", mem_addr);
    endtask

    task automatic test_reset_midreq();
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req, mem_addr, instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL async_reset: req=%b addr=%h valid=%b instr=%h pc=%h, want 0/0/0/0/0",
                     mem_req, mem_addr, instr_valid, instr, instr_pc);
        end
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({mem_req, instr_valid} !== {1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_late_ack: req=%b valid=%b, want 0/0", mem_req, instr_valid);
        end
        step();
        n_cmp++;
        if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL post_reset_req: req=%b addr=%h valid=%b, want 1/00000000/0", mem_req, mem_addr, instr_valid);
        end
        $display("reset_midreq: first request after reset at %h", mem_addr);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_hold();
        test_redirect_req();
        test_kill_update();
        test_wrap();
        test_back_to_back();
        test_reset_midreq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_fetchunit.md
CPU_FETCHUNIT -- requirements
Module: cpu_fetchunit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst, both inputs, 1 bit.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first instruction address after reset, word-aligned.
REQ-003 The port list SHALL be, in this order:
- clk  in  1  rising-edge clock
- rst  in  1  async reset, active-high
- mem_req  out  1  instruction-memory read request
- mem_addr  out  32  request address, word-aligned
- mem_ack  in  1  read data valid on mem_rdata this cycle
- mem_rdata  in  32  instruction word
- instr  out  32  fetched instruction to datapath
- instr_pc  out  32  address of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  datapath accepts instr this cycle
- redirect  in  1  jump/taken-branch request
- redirect_pc  in  32  new fetch address

Function
REQ-004 The FSM SHALL have states IDLE, REQ, HOLD; reset state is IDLE.
REQ-005 IDLE SHALL go to REQ unconditionally on the first clock edge after rst deasserts.
REQ-006 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal the fetch PC; both SHALL stay stable until the cycle mem_ack=1.
REQ-007 On mem_ack in REQ with no pending kill: instr<=mem_rdata, instr_pc<=fetch PC, instr_valid<=1, go to HOLD. instr_valid is registered and rises the cycle after the ack.
REQ-008 In HOLD, mem_req SHALL be 0, and instr/instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-009 A handshake in HOLD (instr_valid & instr_ready) SHALL set fetch PC<=fetch PC+4, clear instr_valid, and enter REQ. mem_req is asserted in the next cycle.
REQ-010 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-011 Redirect SHALL force redirect_pc[1:0] to 2'b00 and load the result as the new fetch PC.
REQ-012 Redirect in HOLD SHALL clear instr_valid and enter REQ at the redirect target. With simultaneous instr_ready, the held instruction counts as accepted and the redirect still wins for the next PC.
REQ-013 Redirect in REQ before ack SHALL NOT drop or change mem_req/mem_addr. Instead it sets a kill flag and records the target.
REQ-014 An ack with the kill flag set, or an ack in the same cycle as a redirect, SHALL be discarded: instr_valid stays 0, the kill flag clears, and REQ is re-entered at the redirect target with a new request the next cycle.
REQ-015 When a new redirect arrives while the kill flag is set, the newest redirect_pc SHALL replace the recorded target.
REQ-016 Redirect in IDLE SHALL replace RESET_PC as the first fetch address.
REQ-017 mem_ack outside REQ SHALL be ignored.

Reset
REQ-018 Assertion of rst SHALL immediately and asynchronously set: state=IDLE, mem_req=0, mem_addr=RESET_PC, fetch PC=RESET_PC, instr=0, instr_pc=RESET_PC, instr_valid=0, kill=0.
REQ-019 Reset in the middle of a request SHALL abandon that request. A late mem_ack after reset is ignored per REQ-017.

Structure
REQ-020 State encodings (IDLE=2'd0, REQ=2'd1, HOLD=2'd2), the instruction width (32), and the PC increment (4) SHALL be defined in the shared package cpu_pkg.
REQ-021 No sub-module is required. The block SHALL be a single module, with next-state and next-PC logic in one combinational block and all state in one async-reset sequential block.
REQ-022 The instr output SHALL feed the datapath instruction input directly; opcode = instr[7:0] is decoded downstream.

Verification
REQ-023 Reset release, RESET_PC=0, mem_ack one cycle after each request, instr_ready held 1:
- mem_addr sequence SHALL be 0, 4, 8.
- instr_valid SHALL pulse with instr_pc = 0, 4, 8.
REQ-024 Backpressure: hold instr_ready=0 for 5 cycles after instr_valid.
- instr/instr_pc SHALL be stable throughout and mem_req SHALL stay 0.
- After the handshake, mem_addr SHALL be prior+4.
REQ-025 Redirect in HOLD with redirect_pc=32'h0000_0103:
- instr_valid SHALL drop next cycle.
- The next request SHALL be at mem_addr=32'h0000_0100.
REQ-026 Redirect to 32'h40 during a 3-cycle-latency fetch of 32'h8:
- mem_addr SHALL stay 8 until ack.
- The data SHALL be discarded (no instr_valid).
- The next request SHALL be at 32'h40.
REQ-027 Wrap: redirect to 32'hFFFF_FFFC, then accept that instruction; the next mem_addr SHALL be 32'h0.
REQ-028 Assert rst while mem_req=1, then deliver mem_ack during reset:
- Outputs SHALL match REQ-018 immediately.
- The first post-reset request SHALL be at RESET_PC.
